// File: rtl/mem_access_ctrl_if.sv
// Data-bus request/handshake bundle between the MEM-stage access controller
// (master) and the data memory slave.
interface mem_access_ctrl_if #(
  parameter int DW = 32
) ();
  logic          data_req;
  logic          data_wr;
  logic [3:0]    data_wstrb;
  logic [DW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic          data_addr_ok;
  logic          data_data_ok;
  logic [DW-1:0] data_rdata;

  modport master (
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: turns a one-cycle load/store into a
// req/addr_ok/data_ok bus transaction, stalls the pipeline and drains cancelled accesses.
module mem_access_ctrl #(
  parameter int DW = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_memenM,
  input  logic                    i_memwriteM,
  input  logic [DW-1:0]           i_addrM,
  input  logic [DW-1:0]           i_wdataM,
  input  logic [3:0]              i_wstrbM,
  input  logic                    i_exceptM,
  mem_access_ctrl_if.master       bus,
  output logic [DW-1:0]           o_readdataM,
  output logic                    o_stallM,
  output logic                    o_flushW
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t        r_state;
  logic          r_cancel;
  logic          r_wr;
  logic [3:0]    r_wstrb;
  logic [DW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_readdata;
  logic          w_issue;

  assign w_issue     = (r_state == S_IDLE) && i_memenM && !i_exceptM;
  assign o_readdataM = r_readdata;
  assign o_flushW    = o_stallM;

  // Bus drive and stall decode: issue cycle passes M inputs straight through,
  // REQ replays the latched request so fields never move until accepted.
  always_comb begin
    bus.data_req   = 1'b0;
    bus.data_wr    = 1'b0;
    bus.data_wstrb = 4'd0;
    bus.data_addr  = '0;
    bus.data_wdata = '0;
    o_stallM       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_issue) begin
          bus.data_req   = 1'b1;
          bus.data_wr    = i_memwriteM;
          bus.data_wstrb = i_wstrbM;
          bus.data_addr  = i_addrM;
          bus.data_wdata = i_wdataM;
          o_stallM       = 1'b1;
        end else begin
          o_stallM       = 1'b0;
        end
      end
      S_REQ: begin
        bus.data_req   = 1'b1;
        bus.data_wr    = r_wr;
        bus.data_wstrb = r_wstrb;
        bus.data_addr  = r_addr;
        bus.data_wdata = r_wdata;
        o_stallM       = 1'b1;
      end
      S_WAIT, S_DRAIN: o_stallM = 1'b1;
      S_DONE:          o_stallM = 1'b0;
      default:         o_stallM = 1'b0;
    endcase
  end

  // Transaction FSM, request registers, cancel flag and load-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cancel   <= 1'b0;
      r_wr       <= 1'b0;
      r_wstrb    <= 4'd0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_readdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_wr     <= i_memwriteM;
            r_wstrb  <= i_wstrbM;
            r_addr   <= i_addrM;
            r_wdata  <= i_wdataM;
            r_cancel <= 1'b0;
            r_state  <= bus.data_addr_ok ? S_WAIT : S_REQ;
          end
        end
        S_REQ: begin
          // A request already on the bus must be accepted even if cancelled.
          if (bus.data_addr_ok) begin
            r_state  <= (r_cancel || i_exceptM) ? S_DRAIN : S_WAIT;
            r_cancel <= 1'b0;
          end else if (i_exceptM) begin
            r_cancel <= 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.data_data_ok) begin
            if (i_exceptM) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DONE;
              if (!r_wr) begin
                r_readdata <= bus.data_rdata;
              end
            end
          end else if (i_exceptM) begin
            r_state <= S_DRAIN;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        S_DRAIN: begin
          if (bus.data_data_ok) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed and randomized accesses
// against a cycle-count reference model of the bus handshake.
module tb_mem_access_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        memen, memwrite, exceptM;
  logic [31:0] addrM, wdataM;
  logic [3:0]  wstrbM;
  logic [31:0] readdata;
  logic        stall, flush;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_rd;

  mem_access_ctrl_if bus_if ();

  mem_access_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .i_memenM    (memen),
    .i_memwriteM (memwrite),
    .i_addrM     (addrM),
    .i_wdataM    (wdataM),
    .i_wstrbM    (wstrbM),
    .i_exceptM   (exceptM),
    .bus         (bus_if),
    .o_readdataM (readdata),
    .o_stallM    (stall),
    .o_flushW    (flush)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    memen                = 1'b0;
    memwrite             = 1'b0;
    exceptM              = 1'b0;
    addrM                = $urandom;
    wdataM               = $urandom;
    wstrbM               = 4'($urandom);
    bus_if.data_addr_ok  = 1'b0;
    bus_if.data_data_ok  = 1'b0;
    bus_if.data_rdata    = $urandom;
  endtask

  task automatic check_all_zero(input string tag);
    check_value({tag, "_req"},   32'(bus_if.data_req),   32'd0);
    check_value({tag, "_wr"},    32'(bus_if.data_wr),    32'd0);
    check_value({tag, "_wstrb"}, 32'(bus_if.data_wstrb), 32'd0);
    check_value({tag, "_addr"},  bus_if.data_addr,       32'd0);
    check_value({tag, "_wdata"}, bus_if.data_wdata,      32'd0);
    check_value({tag, "_rdata"}, readdata,               32'd0);
    check_value({tag, "_stall"}, 32'(stall),             32'd0);
    check_value({tag, "_flush"}, 32'(flush),             32'd0);
  endtask

  // One access: addr_ok in cycle a (0 = issue), data_ok in cycle a+d, exceptM
  // pulsed in cycle e (e < 1 means no cancellation). Stall covers cycles 0..a+d.
  task automatic run_access(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] ws, input logic [31:0] rdv,
                            input int a, input int d, input int e);
    bit cancelled;
    cancelled = (e >= 1) && (e <= a + d);
    for (int c = 0; c <= a + d; c++) begin
      memen               = 1'b1;
      memwrite            = wr;
      addrM               = addr;
      wdataM              = wd;
      wstrbM              = ws;
      exceptM             = (c == e);
      bus_if.data_addr_ok = (c == a);
      bus_if.data_data_ok = (c == a + d);
      bus_if.data_rdata   = (c == a + d) ? rdv : $urandom;
      @(negedge clk);
      check_value("stall", 32'(stall), 32'd1);
      check_value("flush", 32'(flush), 32'd1);
      check_value("req",   32'(bus_if.data_req), 32'(c <= a));
      if (c <= a) begin
        check_value("addr", bus_if.data_addr, addr);
        check_value("wr",   32'(bus_if.data_wr), 32'(wr));
        if (wr) begin
          check_value("wdata", bus_if.data_wdata, wd);
          check_value("wstrb", 32'(bus_if.data_wstrb), 32'(ws));
        end
      end
      check_value("rd_hold", readdata, exp_rd);
      @(posedge clk);
      #1;
    end
    if (!cancelled) begin
      if (!wr) exp_rd = rdv;
      // Release cycle: the next instruction is already presented but must be ignored.
      drive_idle();
      memen    = 1'b1;
      memwrite = 1'($urandom);
      @(negedge clk);
      check_value("done_stall", 32'(stall), 32'd0);
      check_value("done_flush", 32'(flush), 32'd0);
      check_value("done_req",   32'(bus_if.data_req), 32'd0);
      check_value("done_rdata", readdata, exp_rd);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int a, d, e;
    drive_idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_rd = 32'd0;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;

    // Exception in IDLE: nothing issues.
    memen   = 1'b1;
    exceptM = 1'b1;
    @(negedge clk);
    check_value("noissue_req",   32'(bus_if.data_req), 32'd0);
    check_value("noissue_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;

    run_access(1'b0, 32'h0000_1000, 32'd0, 4'b0000, 32'hDEAD_BEEF, 0, 1, -1);
    run_access(1'b1, 32'h0000_2000, 32'h0000_ABCD, 4'b0011, 32'h5555_AAAA, 3, 2, -1);
    run_access(1'b0, 32'h0000_3000, 32'd0, 4'b0000, 32'h1234_5678, 0, 3, 1);
    run_access(1'b0, 32'h0000_3004, 32'd0, 4'b0000, 32'h0BAD_F00D, 3, 1, 1);
    run_access(1'b0, 32'h0000_0020, 32'd0, 4'b0000, 32'hA5A5_0020, 0, 1, -1);
    run_access(1'b0, 32'h0000_0024, 32'd0, 4'b0000, 32'hA5A5_0024, 0, 1, -1);

    // Reset during WAIT.
    memen               = 1'b1;
    memwrite            = 1'b0;
    exceptM             = 1'b0;
    addrM               = 32'h0000_0040;
    bus_if.data_addr_ok = 1'b1;
    bus_if.data_data_ok = 1'b0;
    @(posedge clk);
    #1;
    drive_idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    exp_rd = 32'd0;
    @(negedge clk);
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    run_access(1'b0, 32'h0000_0044, 32'd0, 4'b0000, 32'hCAFE_0044, 1, 2, -1);

    for (int i = 0; i < 60; i++) begin
      a = int'($urandom_range(0, 3));
      d = int'($urandom_range(1, 3));
      e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, a + d)) : -1;
      run_access(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom, a, d, e);
    end
    run_access(1'b0, 32'h0000_0080, 32'd0, 4'b0000, 32'h7777_0080, 0, 1, -1);

    drive_idle();
    @(negedge clk);
    check_value("end_stall", 32'(stall), 32'd0);
    check_value("end_rdata", readdata, exp_rd);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
